// File: rtl/scp_alarm_ctrl_if.sv
// Action/cheat/ack inputs and alarm outputs
// exchanged between the facility bus and scp_alarm_ctrl.
interface scp_alarm_if;
    logic       a1;
    logic       a2;
    logic       a3;
    logic       cheat_out;
    logic       ack;
    logic [1:0] alarm_state;
    logic       siren;
    logic       lockdown;
    logic [5:0] timer;
    logic [7:0] breach_count;

    modport master (
        output a1, a2, a3, cheat_out, ack,
        input  alarm_state, siren, lockdown, timer, breach_count
    );

    modport slave (
        input  a1, a2, a3, cheat_out, ack,
        output alarm_state, siren, lockdown, timer, breach_count
    );
endinterface

// File: rtl/scp_alarm_ctrl.sv
// Latched, escalating facility alarm driven by the
// scp_079 action and cheat flags.
module scp_alarm_ctrl #(
    parameter int ESC_SECS  = 10,
    parameter int LOCK_SECS = 20
) (
    input logic        clock,
    input logic        reset,
    scp_alarm_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_WARN  = 2'b01;
    localparam logic [1:0] S_ALARM = 2'b10;
    localparam logic [1:0] S_LOCK  = 2'b11;

    localparam logic [5:0] ESC_T  = 6'(ESC_SECS - 1);
    localparam logic [5:0] LOCK_T = 6'(LOCK_SECS - 1);

    logic [1:0] r_state;
    logic       r_siren;
    logic       r_lock;
    logic [5:0] r_timer;
    logic [7:0] r_count;

    logic [1:0] w_nxt;
    logic       w_siren;
    logic       w_act;
    logic       w_low;

    assign w_act = bus.a1 | bus.a2 | bus.a3;
    assign w_low = bus.a1 | bus.a2;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.cheat_out)  w_nxt = S_LOCK;
                else if (bus.a3)    w_nxt = S_ALARM;
                else if (w_low)     w_nxt = S_WARN;
            end
            S_WARN: begin
                if (bus.cheat_out)  w_nxt = S_LOCK;
                else if (bus.a3)    w_nxt = S_ALARM;
                else if (w_low) begin
                    if (r_timer == ESC_T) w_nxt = S_ALARM;
                end
                else                w_nxt = S_IDLE;
            end
            S_ALARM: begin
                // Timeout outranks a valid ack on the same edge
                if (bus.cheat_out)           w_nxt = S_LOCK;
                else if (r_timer == LOCK_T)  w_nxt = S_LOCK;
                else if (bus.ack && !w_act)  w_nxt = S_IDLE;
            end
            default: begin
                if (bus.ack && !w_act && !bus.cheat_out)
                    w_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_siren = 1'b1;
        case (w_nxt)
            S_IDLE:  w_siren = 1'b0;
            S_WARN:  w_siren = (r_state != S_WARN) ? 1'b1 : ~r_siren;
            default: w_siren = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_siren <= 1'b0;
            r_lock  <= 1'b0;
            r_timer <= 6'd0;
            r_count <= 8'd0;
        end else begin
            r_state <= w_nxt;
            r_siren <= w_siren;
            r_lock  <= (w_nxt == S_LOCK);
            if (w_nxt != r_state)
                r_timer <= 6'd0;
            else if (r_timer != 6'd63)
                r_timer <= r_timer + 6'd1;
            if (r_state == S_IDLE && w_nxt != S_IDLE && r_count != 8'hFF)
                r_count <= r_count + 8'd1;
        end
    end

    assign bus.alarm_state  = r_state;
    assign bus.siren        = r_siren;
    assign bus.lockdown     = r_lock;
    assign bus.timer        = r_timer;
    assign bus.breach_count = r_count;
endmodule

// File: tb/tb_scp_alarm_ctrl.sv
// Scoreboard bench for scp_alarm_ctrl: stimulus pushes
// expected outputs, a monitor pops and compares after each edge.
module tb_scp_alarm_ctrl;
    localparam logic [5:0] A1  = 6'b000001;
    localparam logic [5:0] A2  = 6'b000010;
    localparam logic [5:0] A3  = 6'b000100;
    localparam logic [5:0] ACK = 6'b001000;
    localparam logic [5:0] CH  = 6'b010000;
    localparam logic [5:0] RST = 6'b100000;
    localparam logic [5:0] NON = 6'b000000;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] WRN = 2'b01;
    localparam logic [1:0] ALM = 2'b10;
    localparam logic [1:0] LCK = 2'b11;

    typedef struct packed {
        logic [1:0] st;
        logic       sir;
        logic       lk;
        logic [5:0] tm;
        logic [7:0] bc;
    } obs_t;

    typedef struct {
        string nm;
        obs_t  v;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    scp_alarm_if bus();

    scp_alarm_ctrl #(.ESC_SECS(10), .LOCK_SECS(20)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step(input string nm, input logic [5:0] in,
                        input logic [1:0] st, input logic sir,
                        input logic [5:0] tm, input logic [7:0] bc);
        exp_t e;
        {reset, bus.cheat_out, bus.ack, bus.a3, bus.a2, bus.a1} = in;
        e.nm = nm;
        e.v  = '{st: st, sir: sir, lk: (st == LCK), tm: tm, bc: bc};
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        obs_t a;
        forever begin
            @(posedge clock);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{st: bus.alarm_state, sir: bus.siren, lk: bus.lockdown,
                      tm: bus.timer, bc: bus.breach_count};
                checks++;
                if (a !== e.v) begin
                    errors++;
                    $display("FAIL %s: got st=%b sir=%b lk=%b tm=%0d bc=%0d, want st=%b sir=%b lk=%b tm=%0d bc=%0d",
                             e.nm, a.st, a.sir, a.lk, a.tm, a.bc,
                             e.v.st, e.v.sir, e.v.lk, e.v.tm, e.v.bc);
                end
            end
        end
    end

    initial begin : stim
        int bc;
        int tm;
        step("rst0", RST, IDL, 0, 0, 0);
        step("rst1", RST | A2, IDL, 0, 0, 0);

        step("t1_enter", A2, WRN, 1, 0, 1);
        for (int i = 1; i < 10; i++)
            step("t1_warn", A2, WRN, logic'(i % 2 == 0), 6'(i), 1);
        step("t1_esc", A2, ALM, 1, 0, 1);

        step("rst", RST, IDL, 0, 0, 0);
        step("t2_w0", A1, WRN, 1, 0, 1);
        step("t2_w1", A1, WRN, 0, 1, 1);
        step("t2_w2", A1, WRN, 1, 2, 1);
        step("t2_clr", NON, IDL, 0, 0, 1);
        step("t2_idle", NON, IDL, 0, 1, 1);

        step("rst", RST, IDL, 0, 0, 0);
        step("t3_a0", A3, ALM, 1, 0, 1);
        step("t3_a1", A3, ALM, 1, 1, 1);
        step("t3_ackign", A3 | ACK, ALM, 1, 2, 1);
        step("t3_ack", ACK, IDL, 0, 0, 1);

        step("rst", RST, IDL, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step("t4_alarm", A3, ALM, 1, 6'(i), 1);
        step("t4_lock", A3, LCK, 1, 0, 1);
        step("t4_hold", A3, LCK, 1, 1, 1);
        step("t4_ack", ACK, IDL, 0, 0, 1);

        step("rst", RST, IDL, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step("t4b_alarm", A3, ALM, 1, 6'(i), 1);
        step("t4b_tmo_ack", ACK, LCK, 1, 0, 1);
        step("t4b_ch_ack", CH | ACK, LCK, 1, 1, 1);
        step("t4b_ack", ACK, IDL, 0, 0, 1);

        step("rst", RST, IDL, 0, 0, 0);
        step("t4c_alarm", A3, ALM, 1, 0, 1);
        step("t4c_ch_ack", CH | ACK, LCK, 1, 0, 1);

        step("rst", RST, IDL, 0, 0, 0);
        step("t5_cheat", CH | ACK, LCK, 1, 0, 1);
        for (int k = 1; k < 66; k++) begin
            tm = (k > 63) ? 63 : k;
            step("t5_hold", CH | ACK, LCK, 1, 6'(tm), 1);
        end
        step("t5_ack", ACK, IDL, 0, 0, 1);

        step("rst", RST, IDL, 0, 0, 0);
        for (int k = 0; k < 260; k++) begin
            bc = (k + 1 > 255) ? 255 : k + 1;
            step("t6_warn", A1, WRN, 1, 0, 8'(bc));
            step("t6_idle", NON, IDL, 0, 0, 8'(bc));
        end
        step("t6_lock", CH, LCK, 1, 0, 255);
        step("t6_rst", CH | RST, IDL, 0, 0, 0);

        {reset, bus.cheat_out, bus.ack, bus.a3, bus.a2, bus.a1} = NON;
        @(posedge clock);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
